// File: rtl/idu1_scoreboard_pkg.sv
// Shared types and default sizes for the IDU1 register/unit scoreboard.
package idu1_scoreboard_pkg;

  localparam int unsigned SB_NREGS        = 32;
  localparam int unsigned SB_NUM_WB       = 2;
  localparam int unsigned SB_MAX_INFLIGHT = 3;
  localparam int unsigned SB_NUM_CLASSES  = 4;
  localparam int unsigned SB_CLASS_DEPTH  = 2;
  localparam int unsigned SB_AW           = 5;
  localparam int unsigned SB_CNT_W        = $clog2(SB_MAX_INFLIGHT + 1);
  localparam int unsigned SB_OCC_W        = $clog2(SB_CLASS_DEPTH + 1);

  typedef enum logic [1:0] {
    SB_MUL = 2'd0,
    SB_DIV = 2'd1,
    SB_LSU = 2'd2,
    SB_MAC = 2'd3
  } sb_class_e;

  typedef struct packed {
    logic                      valid;
    logic                      rs1_en;
    logic [SB_AW-1:0]          rs1_addr;
    logic                      rs2_en;
    logic [SB_AW-1:0]          rs2_addr;
    logic                      rd_en;
    logic [SB_AW-1:0]          rd_addr;
    logic [SB_NUM_CLASSES-1:0] cls;
  } sb_issue_t;

  function automatic logic [SB_NUM_CLASSES-1:0] sb_class_onehot(input sb_class_e c);
    return SB_NUM_CLASSES'(1) << c;
  endfunction

endpackage

// File: rtl/sb_updown_cnt.sv
// Saturating up/down counter: one increment, multi-decrement, clamps at 0 and flags underflow.
module sb_updown_cnt #(
  parameter int unsigned MAX_VAL = 3,
  parameter int unsigned DEC_MAX = 2,
  parameter int unsigned W       = $clog2(MAX_VAL + 1),
  parameter int unsigned DW      = $clog2(DEC_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_inc,
  input  logic [DW-1:0] i_dec,
  output logic [W-1:0]  o_cnt,
  output logic          o_full_c,
  output logic          o_uflow_c
);

  localparam int unsigned EW = ((W > DW) ? W : DW) + 1;

  logic [W-1:0]  r_cnt;
  logic [EW-1:0] w_cur;
  logic [EW-1:0] w_dec;
  logic [EW-1:0] w_base;
  logic [EW-1:0] w_nxt;

  // Underflow is judged against the current count, before this cycle's increment.
  assign w_cur     = EW'(r_cnt);
  assign w_dec     = EW'(i_dec);
  assign o_uflow_c = (w_dec > w_cur);
  assign w_base    = o_uflow_c ? '0 : (w_cur - w_dec);
  assign w_nxt     = w_base + EW'(i_inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= (w_nxt > EW'(MAX_VAL)) ? W'(MAX_VAL) : W'(w_nxt);
    end
  end

  assign o_cnt    = r_cnt;
  assign o_full_c = (r_cnt == W'(MAX_VAL));

endmodule

// File: rtl/idu1_scoreboard.sv
// Per-register RAW/WAW and per-class occupancy scoreboard at the decode/execute boundary.
// Optional SB_BYPASS_EN: writebacks/completions release hazards in the same cycle.
module idu1_scoreboard
  import idu1_scoreboard_pkg::*;
#(
  parameter int unsigned NREGS        = SB_NREGS,
  parameter int unsigned NUM_WB       = SB_NUM_WB,
  parameter int unsigned MAX_INFLIGHT = SB_MAX_INFLIGHT,
  parameter int unsigned NUM_CLASSES  = SB_NUM_CLASSES,
  parameter int unsigned CLASS_DEPTH  = SB_CLASS_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     issue_valid,
  input  logic                     issue_rs1_en,
  input  logic                     issue_rs2_en,
  input  logic                     issue_rd_en,
  input  logic [4:0]               issue_rs1_addr,
  input  logic [4:0]               issue_rs2_addr,
  input  logic [4:0]               issue_rd_addr,
  input  logic [NUM_CLASSES-1:0]   issue_class,
  output logic                     issue_ready,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [5*NUM_WB-1:0]      wb_rd_addr,
  input  logic [NUM_CLASSES-1:0]   cmpl_valid,
  output logic                     hazard_raw,
  output logic                     hazard_waw,
  output logic                     hazard_struct,
  output logic                     sb_busy,
  output logic                     sb_err
);

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned OCC_W = $clog2(CLASS_DEPTH + 1);
  localparam int unsigned WBC_W = $clog2(NUM_WB + 1);

  sb_issue_t                          w_iss;
  logic                               w_issue;
  logic [NREGS-1:0][WBC_W-1:0]        w_wb_dec;
  logic [NREGS-1:0][CNT_W-1:0]        w_cnt;
  logic [NREGS-1:0]                   w_full;
  logic [NREGS-1:0]                   w_uflow;
  logic [NREGS-1:0]                   w_busy;
  logic [NREGS-1:0][NUM_CLASSES-1:0]  r_cls;
  logic [NUM_CLASSES-1:0][OCC_W-1:0]  w_occ;
  logic [NUM_CLASSES-1:0]             w_occ_full;
  logic [NUM_CLASSES-1:0]             w_occ_uflow;
  logic [NUM_CLASSES-1:0]             w_struct;
  logic                               r_err;

  always_comb begin
    w_iss          = '0;
    w_iss.valid    = issue_valid;
    w_iss.rs1_en   = issue_rs1_en;
    w_iss.rs1_addr = issue_rs1_addr;
    w_iss.rs2_en   = issue_rs2_en;
    w_iss.rs2_addr = issue_rs2_addr;
    w_iss.rd_en    = issue_rd_en;
    w_iss.rd_addr  = issue_rd_addr;
    w_iss.cls      = issue_class;
  end

  // Count writebacks per register; two ports on one register decrement by two.
  always_comb begin
    w_wb_dec = '0;
    for (int p = 0; p < int'(NUM_WB); p++) begin
      if (wb_valid[p]) begin
        w_wb_dec[wb_rd_addr[5*p +: 5]] = w_wb_dec[wb_rd_addr[5*p +: 5]] + WBC_W'(1);
      end
    end
  end

  // x0 is never tracked; a writeback naming it is a writeback with nothing pending.
  assign w_cnt[0]   = '0;
  assign w_full[0]  = 1'b0;
  assign w_busy[0]  = 1'b0;
  assign w_uflow[0] = |w_wb_dec[0];

  for (genvar r = 1; r < int'(NREGS); r++) begin : g_reg
    logic w_inc;
    assign w_inc = w_issue & w_iss.rd_en & (w_iss.rd_addr == 5'(r));

    sb_updown_cnt #(
      .MAX_VAL (MAX_INFLIGHT),
      .DEC_MAX (NUM_WB),
      .W       (CNT_W),
      .DW      (WBC_W)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .i_inc     (w_inc),
      .i_dec     (w_wb_dec[r]),
      .o_cnt     (w_cnt[r]),
      .o_full_c  (w_full[r]),
      .o_uflow_c (w_uflow[r])
    );

`ifdef SB_BYPASS_EN
    assign w_busy[r] = (int'(w_cnt[r]) > int'(w_wb_dec[r]));
`else
    assign w_busy[r] = (w_cnt[r] != '0);
`endif
  end

  for (genvar c = 0; c < int'(NUM_CLASSES); c++) begin : g_cls
    sb_updown_cnt #(
      .MAX_VAL (CLASS_DEPTH),
      .DEC_MAX (1),
      .W       (OCC_W),
      .DW      (1)
    ) u_occ (
      .clk       (clk),
      .rst       (rst),
      .i_inc     (w_issue & w_iss.cls[c]),
      .i_dec     (cmpl_valid[c]),
      .o_cnt     (w_occ[c]),
      .o_full_c  (w_occ_full[c]),
      .o_uflow_c (w_occ_uflow[c])
    );

`ifdef SB_BYPASS_EN
    assign w_struct[c] = w_iss.cls[c] & w_occ_full[c] & ~cmpl_valid[c];
`else
    assign w_struct[c] = w_iss.cls[c] & w_occ_full[c];
`endif
  end

  // Same-class writers retire in order, so only a class change or a full count blocks WAW.
  always_comb begin
    hazard_raw    = (w_iss.rs1_en & w_busy[w_iss.rs1_addr]) |
                    (w_iss.rs2_en & w_busy[w_iss.rs2_addr]);
    hazard_waw    = w_iss.rd_en & (w_iss.rd_addr != '0) & (w_cnt[w_iss.rd_addr] != '0) &
                    ((r_cls[w_iss.rd_addr] != w_iss.cls) | w_full[w_iss.rd_addr]);
    hazard_struct = |w_struct;
    issue_ready   = ~(hazard_raw | hazard_waw | hazard_struct);
  end

  assign w_issue = w_iss.valid & issue_ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cls <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_issue & w_iss.rd_en & (w_iss.rd_addr != '0)) begin
        r_cls[w_iss.rd_addr] <= w_iss.cls;
      end
      if ((|w_uflow) | (|w_occ_uflow)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign sb_err  = r_err;
  assign sb_busy = (w_cnt != '0) | (w_occ != '0);

endmodule
